// File: rtl/score_bcd_converter_if.sv
// score_bcd_converter_if: handshake/data bundle between the score producer and the
// binary-to-BCD converter.
//   score_in   : binary score, sampled by the converter only when it accepts a start
//   start      : conversion request, level-sampled every rising edge
//   busy       : conversion in progress
//   done       : one-cycle pulse, high the cycle digits_out updates
//   digits_out : packed BCD digits, digit 0 least significant
//   saturated  : last completed conversion was clamped to all nines
//   blank_mask : leading-zero mask (present only when SCORE_BCD_BLANK_EN is defined)
// master modport: score producer side. slave modport: converter side.
interface score_bcd_converter_if #(
  parameter int unsigned BIN_WIDTH = 26,
  parameter int unsigned DIGITS    = 6
) ();

  logic [BIN_WIDTH-1:0] score_in;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic [4*DIGITS-1:0]  digits_out;
  logic                 saturated;
`ifdef SCORE_BCD_BLANK_EN
  logic [DIGITS-1:0]    blank_mask;

  modport master (
    output score_in, start,
    input  busy, done, digits_out, saturated, blank_mask
  );

  modport slave (
    input  score_in, start,
    output busy, done, digits_out, saturated, blank_mask
  );
`else
  modport master (
    output score_in, start,
    input  busy, done, digits_out, saturated
  );

  modport slave (
    input  score_in, start,
    output busy, done, digits_out, saturated
  );
`endif

endinterface

// File: rtl/score_bcd_converter.sv
// score_bcd_converter: iterative double-dabble binary-to-BCD converter.
// A start in IDLE captures score_in; BIN_WIDTH shift-and-add-3 iterations later the
// result (or all nines if the snapshot exceeded SAT_VALUE) is registered onto
// digits_out together with a one-cycle done pulse. A start seen while busy is
// remembered and launches one more conversion right after the current one.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : score_bcd_converter_if.slave (score_in, start -> busy, done,
//           digits_out, saturated [, blank_mask])
// Optional feature: define SCORE_BCD_BLANK_EN to add the registered blank_mask output
// (bit i set when digit i and every higher digit are zero; bit 0 never set).
module score_bcd_converter #(
  parameter int unsigned BIN_WIDTH = 26,
  parameter int unsigned DIGITS    = 6,
  parameter int unsigned SAT_VALUE = 999999
) (
  input logic                  clk,
  input logic                  reset,
  score_bcd_converter_if.slave bus
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(BIN_WIDTH + 1);
  localparam int unsigned CmpW = (BIN_WIDTH > 32) ? BIN_WIDTH : 32;
  localparam logic [CntW-1:0] LastIter = CntW'(BIN_WIDTH - 1);
  localparam logic [BcdW-1:0] AllNines = {DIGITS{4'h9}};

  typedef enum logic [0:0] {StIdle, StConvert} state_e;

  state_e               state_q;
  logic [BIN_WIDTH-1:0] bin_q;
  logic [BcdW-1:0]      bcd_q;
  logic [CntW-1:0]      cnt_q;
  logic                 sat_flag_q;
  logic                 pending_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 saturated_q;
  logic [BcdW-1:0]      digits_q;

  logic [BcdW-1:0]      bcd_adj;
  logic [BcdW-1:0]      bcd_shift;
  logic [BIN_WIDTH-1:0] bin_shift;
  logic [BcdW-1:0]      digits_nxt;
  logic                 score_over;

  // One double-dabble iteration: correct each nibble, then shift {bcd, bin} left.
  // The bit leaving the top nibble is dropped; saturation covers those inputs.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    {bcd_shift, bin_shift} = {bcd_adj[BcdW-2:0], bin_q, 1'b0};
  end

  assign score_over = CmpW'(bus.score_in) > CmpW'(SAT_VALUE);
  assign digits_nxt = sat_flag_q ? AllNines : bcd_shift;

`ifdef SCORE_BCD_BLANK_EN
  logic [DIGITS-1:0] blank_nxt;
  logic [DIGITS-1:0] blank_q;
  logic              upper_zero;

  always_comb begin
    blank_nxt  = '0;
    upper_zero = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      upper_zero   = upper_zero && (digits_nxt[4*i +: 4] == 4'd0);
      blank_nxt[i] = upper_zero;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      sat_flag_q  <= 1'b0;
      pending_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      saturated_q <= 1'b0;
      digits_q    <= '0;
`ifdef SCORE_BCD_BLANK_EN
      blank_q     <= {{(DIGITS-1){1'b1}}, 1'b0};
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          // A request remembered during the previous conversion counts as a start
          // here; it is consumed by this launch.
          if (bus.start || pending_q) begin
            bin_q      <= bus.score_in;
            bcd_q      <= '0;
            cnt_q      <= '0;
            sat_flag_q <= score_over;
            pending_q  <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= StConvert;
          end
        end
        StConvert: begin
          if (bus.start) begin
            pending_q <= 1'b1;
          end
          bin_q <= bin_shift;
          bcd_q <= bcd_shift;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == LastIter) begin
            digits_q    <= digits_nxt;
            saturated_q <= sat_flag_q;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
`ifdef SCORE_BCD_BLANK_EN
            blank_q     <= blank_nxt;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.digits_out = digits_q;
  assign bus.saturated  = saturated_q;
`ifdef SCORE_BCD_BLANK_EN
  assign bus.blank_mask = blank_q;
`endif

endmodule
